sorter_8_drain: RTL and testbench

- Consumer end of the `sorter_8` output interface.
- Accepts one 8-lane sorted block per cycle from the sorter (valid + flat array) and buffers whole blocks in a FIFO.
- Serialises each block into one `tuple_pair_t` per cycle over a ready/valid stream, in lane order 0..7.
- Drives `stall` back toward the sorter's feeder so that blocks still in the 6-stage sorter pipeline always fit in the FIFO.

---
 rtl/sorter_8_drain_pkg.sv | 28 ++
 rtl/aoc5_block_fifo.sv | 57 +++++
 rtl/sorter_8_drain.sv | 133 +++++++++++++
 tb/tb_sorter_8_drain.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sorter_8_drain_pkg.sv
// Shared types for the sorter_8 output side: lane pair type, flat block width,
// sorter pipeline latency and the drain FSM state encoding.
package sorter_8_drain_pkg;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
  } tuple_pair_t;

  localparam int unsigned PAIR_W           = $bits(tuple_pair_t);
  localparam int unsigned LANES            = 8;
  localparam int unsigned ARR_8_FLAT_WIDTH = LANES * PAIR_W;
  localparam int unsigned SORTER_PIPE_LAT  = 6;

  typedef enum logic {
    ST_IDLE,
    ST_EMIT
  } drain_state_e;

  // Lane 0 occupies the least significant PAIR_W bits of the flat block.
  function automatic tuple_pair_t index_flat(input logic [ARR_8_FLAT_WIDTH-1:0] flat,
                                             input logic [2:0]                  lane);
    tuple_pair_t [LANES-1:0] lanes;
    lanes = flat;
    return lanes[lane];
  endfunction

endpackage

// File: rtl/aoc5_block_fifo.sv
// Generic block FIFO, power-of-two depth, registered read pointer with
// combinational read data; push on full is accepted only alongside a pop.
module aoc5_block_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != FULL_CNT) || do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

endmodule

// File: rtl/sorter_8_drain.sv
// Buffers sorted 8-lane blocks from sorter_8 and serialises them one pair per
// cycle over ready/valid, with registered backpressure toward the feeder.
module sorter_8_drain
  import sorter_8_drain_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned PIPE_LAT  = SORTER_PIPE_LAT,
  parameter bit          SKIP_ZERO = 1'b1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        valid_in,
  input  logic [ARR_8_FLAT_WIDTH-1:0] pairs_in_flat,
  output logic                        stall,
  output tuple_pair_t                 pair_out,
  output logic                        pair_valid,
  input  logic                        pair_ready,
  output logic                        idle,
  output logic                        overflow
);

  localparam int unsigned CW       = $clog2(DEPTH) + 1;
  localparam int unsigned STALL_AT = DEPTH - PIPE_LAT - 1;

  drain_state_e                state_q, state_d;
  logic [2:0]                  lane_q, lane_d;
  logic [ARR_8_FLAT_WIDTH-1:0] emit_q, emit_d;
  tuple_pair_t                 pair_out_q, pair_out_d;
  logic                        pair_valid_q, pair_valid_d;
  logic                        stall_q, stall_d;
  logic                        idle_q, idle_d;
  logic                        overflow_q, overflow_d;

  logic                        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ARR_8_FLAT_WIDTH-1:0] fifo_rdata;
  logic [CW-1:0]               fifo_count, count_next;
  tuple_pair_t                 cur_pair, next_pair;
  logic                        skip, advance;

  aoc5_block_fifo #(
    .WIDTH (ARR_8_FLAT_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clock),
    .rst_n (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (pairs_in_flat),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    emit_d   = emit_q;
    fifo_pop = 1'b0;

    cur_pair = index_flat(emit_q, lane_q);
    skip     = SKIP_ZERO && (cur_pair == '0);
    advance  = skip || pair_ready;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          emit_d   = fifo_rdata;
          lane_d   = '0;
          state_d  = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (advance) begin
          if (lane_q == 3'd7) begin
            lane_d = '0;
            // Back-to-back blocks reload the emit register on the last lane.
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              emit_d   = fifo_rdata;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            lane_d = lane_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    fifo_push  = valid_in && (!fifo_full || fifo_pop);
    overflow_d = overflow_q || (valid_in && !fifo_push);
    count_next = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
    stall_d    = (count_next >= CW'(STALL_AT));

    // Outputs are registered from the next lane so they line up with lane_q.
    next_pair    = index_flat(emit_d, lane_d);
    pair_valid_d = (state_d == ST_EMIT) && !(SKIP_ZERO && (next_pair == '0));
    pair_out_d   = pair_valid_d ? next_pair : '0;
    idle_d       = (state_d == ST_IDLE) && (count_next == '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      lane_q       <= '0;
      emit_q       <= '0;
      pair_out_q   <= '0;
      pair_valid_q <= 1'b0;
      stall_q      <= 1'b0;
      idle_q       <= 1'b1;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      emit_q       <= emit_d;
      pair_out_q   <= pair_out_d;
      pair_valid_q <= pair_valid_d;
      stall_q      <= stall_d;
      idle_q       <= idle_d;
      overflow_q   <= overflow_d;
    end
  end

  assign pair_out   = pair_out_q;
  assign pair_valid = pair_valid_q;
  assign stall      = stall_q;
  assign idle       = idle_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_sorter_8_drain.sv
// Randomised bench for sorter_8_drain: two instances (zero-skip on/off) share
// stimulus and are scored against per-instance queues of expected pairs.
module tb_sorter_8_drain;
  import sorter_8_drain_pkg::*;

  localparam int unsigned DEPTH     = 16;
  localparam int unsigned PIPE      = SORTER_PIPE_LAT;
  localparam int unsigned STALL_LVL = DEPTH - PIPE - 1;

  typedef tuple_pair_t blk_t [8];

  logic                        clock = 1'b0;
  logic                        reset;
  logic                        valid_in;
  logic                        pair_ready;
  logic [ARR_8_FLAT_WIDTH-1:0] pairs_in_flat;

  logic        stall_s, pv_s, idle_s, ovf_s;
  logic        stall_k, pv_k, idle_k, ovf_k;
  tuple_pair_t po_s, po_k;

  always #5 clock = ~clock;

  sorter_8_drain #(.DEPTH(DEPTH), .PIPE_LAT(PIPE), .SKIP_ZERO(1'b1)) u_skip (
    .clock(clock), .reset(reset), .valid_in(valid_in), .pairs_in_flat(pairs_in_flat),
    .stall(stall_s), .pair_out(po_s), .pair_valid(pv_s), .pair_ready(pair_ready),
    .idle(idle_s), .overflow(ovf_s)
  );

  sorter_8_drain #(.DEPTH(DEPTH), .PIPE_LAT(PIPE), .SKIP_ZERO(1'b0)) u_keep (
    .clock(clock), .reset(reset), .valid_in(valid_in), .pairs_in_flat(pairs_in_flat),
    .stall(stall_k), .pair_out(po_k), .pair_valid(pv_k), .pair_ready(pair_ready),
    .idle(idle_k), .overflow(ovf_k)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  tuple_pair_t exp_s[$], exp_k[$];
  int          cycle;
  int          first_s, last_s, vcnt_s, first_k, last_k, vcnt_k;
  logic        held_s, held_k;
  tuple_pair_t held_val_s, held_val_k;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic tuple_pair_t rand_pair();
    tuple_pair_t p;
    p.a = 16'($urandom_range(1, 65535));
    p.b = 16'($urandom);
    return p;
  endfunction

  function automatic logic [ARR_8_FLAT_WIDTH-1:0] pack_block(input blk_t blk);
    logic [ARR_8_FLAT_WIDTH-1:0] flat;
    flat = '0;
    for (int i = 7; i >= 0; i--) flat = {flat[ARR_8_FLAT_WIDTH-PAIR_W-1:0], blk[i]};
    return flat;
  endfunction

  task automatic expect_block(input blk_t blk);
    for (int i = 0; i < 8; i++) begin
      exp_k.push_back(blk[i]);
      if (blk[i] != '0) exp_s.push_back(blk[i]);
    end
  endtask

  task automatic clear_stats();
    cycle   = 0;
    first_s = -1; last_s = -1; vcnt_s = 0;
    first_k = -1; last_k = -1; vcnt_k = 0;
  endtask

  // Called at a falling edge with this cycle's inputs already driven.
  task automatic do_cycle();
    if (pv_s) begin
      if (first_s < 0) first_s = cycle;
      last_s = cycle;
      vcnt_s++;
    end
    if (pv_k) begin
      if (first_k < 0) first_k = cycle;
      last_k = cycle;
      vcnt_k++;
    end
    if (held_s) begin
      check("hold_valid_s", pv_s, 1'b1);
      check("hold_data_s", po_s, held_val_s);
    end
    if (held_k) begin
      check("hold_valid_k", pv_k, 1'b1);
      check("hold_data_k", po_k, held_val_k);
    end
    if (pv_s && pair_ready) begin
      check("pending_s", exp_s.size() != 0, 1'b1);
      if (exp_s.size() != 0) check("pair_s", po_s, exp_s.pop_front());
    end
    if (pv_k && pair_ready) begin
      check("pending_k", exp_k.size() != 0, 1'b1);
      if (exp_k.size() != 0) check("pair_k", po_k, exp_k.pop_front());
    end
    held_s = pv_s && !pair_ready;  held_val_s = po_s;
    held_k = pv_k && !pair_ready;  held_val_k = po_k;
    @(posedge clock);
    @(negedge clock);
    cycle++;
  endtask

  task automatic apply_reset();
    reset = 1'b0; valid_in = 1'b0; pair_ready = 1'b0; pairs_in_flat = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    exp_s.delete(); exp_k.delete();
    held_s = 1'b0; held_k = 1'b0;
    clear_stats();
  endtask

  task automatic run_drain(input int max_cycles, input int mode);
    int n;
    n = 0;
    valid_in = 1'b0;
    while ((exp_s.size() != 0 || exp_k.size() != 0) && n < max_cycles) begin
      case (mode)
        0:       pair_ready = 1'b1;
        1:       pair_ready = (cycle % 3 == 0);
        default: pair_ready = ($urandom_range(0, 3) != 0);
      endcase
      do_cycle();
      n++;
    end
    check("drain_left_s", exp_s.size(), 0);
    check("drain_left_k", exp_k.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    blk_t blk, blk2;
    int   n_pushed, first_push, exp_count, arrive[$];
    logic stall_prev, pushed;

    // Reset values, sampled while reset is still asserted.
    reset = 1'b0; valid_in = 1'b0; pair_ready = 1'b0; pairs_in_flat = '0;
    held_s = 1'b0; held_k = 1'b0;
    @(negedge clock);
    check("rst_pv", pv_s, 1'b0);
    check("rst_po", po_s, '0);
    check("rst_stall", stall_s, 1'b0);
    check("rst_ovf", ovf_s, 1'b0);
    check("rst_idle", idle_s, 1'b1);
    check("rst_idle_k", idle_k, 1'b1);

    // 1: single block, latency and idle return.
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      blk[i].a = 16'(i + 1);
      blk[i].b = 16'(i + 2);
    end
    pairs_in_flat = pack_block(blk);
    valid_in = 1'b1; pair_ready = 1'b1;
    expect_block(blk);
    do_cycle();
    valid_in = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 1) check("t1_pv_c1", pv_s, 1'b0);
      if (c == 2) check("t1_pv_c2", pv_s, 1'b1);
      if (c == 10) begin
        check("t1_idle_c10", idle_s, 1'b1);
        check("t1_idle_c10_k", idle_k, 1'b1);
      end
      do_cycle();
    end
    check("t1_first", first_s, 2);
    check("t1_last", last_s, 9);
    check("t1_vcnt", vcnt_s, 8);
    check("t1_left_s", exp_s.size(), 0);

    // 2: same block, ready toggling.
    apply_reset();
    pairs_in_flat = pack_block(blk);
    valid_in = 1'b1; pair_ready = 1'b1;
    expect_block(blk);
    do_cycle();
    run_drain(80, 1);

    // 3: zero lanes 2 and 5.
    apply_reset();
    blk[2] = '0; blk[5] = '0;
    pairs_in_flat = pack_block(blk);
    valid_in = 1'b1; pair_ready = 1'b1;
    expect_block(blk);
    do_cycle();
    run_drain(40, 0);
    check("t3_vcnt_s", vcnt_s, 6);
    check("t3_vcnt_k", vcnt_k, 8);
    check("t3_first_s", first_s, 2);
    check("t3_last_s", last_s, 9);

    // 4: three back-to-back blocks, no bubbles.
    apply_reset();
    pair_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 8; i++) blk[i] = rand_pair();
      pairs_in_flat = pack_block(blk);
      valid_in = 1'b1;
      expect_block(blk);
      do_cycle();
    end
    run_drain(60, 0);
    check("t4_vcnt_s", vcnt_s, 24);
    check("t4_span_s", last_s - first_s + 1, 24);
    check("t4_span_k", last_k - first_k + 1, 24);

    // 5: ready low, feeder behind a PIPE-deep pipeline that sees stall a cycle late.
    apply_reset();
    pair_ready = 1'b0;
    n_pushed = 0; first_push = -1; stall_prev = 1'b0;
    for (int c = 0; c < 60; c++) begin
      exp_count = n_pushed - ((first_push >= 0 && cycle > first_push + 1) ? 1 : 0);
      check("t5_stall_s", stall_s, exp_count >= int'(STALL_LVL));
      check("t5_stall_k", stall_k, exp_count >= int'(STALL_LVL));
      check("t5_ovf", ovf_s, 1'b0);
      if (!stall_prev) arrive.push_back(cycle + int'(PIPE));
      stall_prev = stall_s;
      pushed = (arrive.size() != 0) && (arrive[0] == cycle);
      if (pushed) begin
        void'(arrive.pop_front());
        for (int i = 0; i < 8; i++) blk[i] = rand_pair();
        pairs_in_flat = pack_block(blk);
        if (first_push < 0) first_push = cycle;
      end
      valid_in = pushed;
      do_cycle();
      if (pushed) n_pushed++;
      if (stall_prev && arrive.size() == 0) break;
    end
    valid_in = 1'b0;
    do_cycle();
    check("t5_full_stall", stall_s, 1'b1);
    check("t5_no_ovf", ovf_s, 1'b0);
    check("t5_no_ovf_k", ovf_k, 1'b0);
    valid_in = 1'b1;
    do_cycle();
    valid_in = 1'b0;
    check("t5_ovf_set", ovf_s, 1'b1);
    check("t5_ovf_set_k", ovf_k, 1'b1);
    for (int c = 0; c < 3; c++) do_cycle();
    check("t5_ovf_sticky", ovf_s, 1'b1);

    // 6: asynchronous reset at lane 3 of block 2, then a fresh block.
    apply_reset();
    pair_ready = 1'b1;
    for (int i = 0; i < 8; i++) blk[i] = rand_pair();
    for (int i = 0; i < 8; i++) blk2[i] = rand_pair();
    pairs_in_flat = pack_block(blk); valid_in = 1'b1; expect_block(blk); do_cycle();
    pairs_in_flat = pack_block(blk2); expect_block(blk2); do_cycle();
    valid_in = 1'b0;
    while (cycle < 13) do_cycle();
    check("t6_lane3", po_s, blk2[3]);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_pv", pv_s, 1'b0);
    check("t6_rst_pv_k", pv_k, 1'b0);
    check("t6_rst_stall", stall_s, 1'b0);
    check("t6_rst_idle", idle_s, 1'b1);
    check("t6_rst_po", po_s, '0);
    exp_s.delete(); exp_k.delete();
    held_s = 1'b0; held_k = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    clear_stats();
    for (int i = 0; i < 8; i++) blk[i] = rand_pair();
    pairs_in_flat = pack_block(blk); valid_in = 1'b1; expect_block(blk); do_cycle();
    run_drain(40, 0);
    check("t6_first", first_s, 2);
    check("t6_vcnt", vcnt_s, 8);

    // Random traffic with zero padding, random ready, producer obeying stall.
    apply_reset();
    for (int c = 0; c < 300; c++) begin
      pair_ready = ($urandom_range(0, 3) != 0);
      valid_in = !stall_s && !stall_k && ($urandom_range(0, 2) != 0);
      if (valid_in) begin
        for (int i = 0; i < 8; i++) blk[i] = ($urandom_range(0, 3) == 0) ? '0 : rand_pair();
        pairs_in_flat = pack_block(blk);
        expect_block(blk);
      end
      do_cycle();
    end
    run_drain(2000, 2);
    pair_ready = 1'b1;
    do_cycle();
    check("rnd_ovf_s", ovf_s, 1'b0);
    check("rnd_ovf_k", ovf_k, 1'b0);
    check("rnd_idle_s", idle_s, 1'b1);
    check("rnd_idle_k", idle_k, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
